// File: rtl/rv32im_alu_seq_pkg.sv
// Shared opcode encodings, FSM state encoding and opcode-class helpers for the sequential RV32IM ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rv32im_alu_seq_pkg;

    localparam int API_DATA_WIDTH   = 32;
    localparam int ALU_OPCODE_WIDTH = 5;

    typedef logic [ALU_OPCODE_WIDTH-1:0] alu_op_t;

    // Base integer ops keep their original codes; M-extension ops follow.
    localparam alu_op_t ALU_OPCODE_ADD    = 5'd0;
    localparam alu_op_t ALU_OPCODE_SUB    = 5'd1;
    localparam alu_op_t ALU_OPCODE_AND    = 5'd2;
    localparam alu_op_t ALU_OPCODE_OR     = 5'd3;
    localparam alu_op_t ALU_OPCODE_XOR    = 5'd4;
    localparam alu_op_t ALU_OPCODE_SLT    = 5'd5;
    localparam alu_op_t ALU_OPCODE_SLTU   = 5'd6;
    localparam alu_op_t ALU_OPCODE_SLL    = 5'd7;
    localparam alu_op_t ALU_OPCODE_SRL    = 5'd8;
    localparam alu_op_t ALU_OPCODE_SRA    = 5'd9;
    localparam alu_op_t ALU_OPCODE_MUL    = 5'd10;
    localparam alu_op_t ALU_OPCODE_MULH   = 5'd11;
    localparam alu_op_t ALU_OPCODE_MULHSU = 5'd12;
    localparam alu_op_t ALU_OPCODE_MULHU  = 5'd13;
    localparam alu_op_t ALU_OPCODE_DIV    = 5'd14;
    localparam alu_op_t ALU_OPCODE_DIVU   = 5'd15;
    localparam alu_op_t ALU_OPCODE_REM    = 5'd16;
    localparam alu_op_t ALU_OPCODE_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ALU_ST_IDLE = 2'd0,
        ALU_ST_BUSY = 2'd1,
        ALU_ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic op_is_mul(input alu_op_t op);
        return op inside {ALU_OPCODE_MUL, ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_MULHU};
    endfunction

    function automatic logic op_is_div(input alu_op_t op);
        return op inside {ALU_OPCODE_DIV, ALU_OPCODE_DIVU, ALU_OPCODE_REM, ALU_OPCODE_REMU};
    endfunction

    // Ops whose answer lives in the upper half of the engine (product high / remainder).
    function automatic logic op_sel_hi(input alu_op_t op);
        return op inside {ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_MULHU,
                          ALU_OPCODE_REM, ALU_OPCODE_REMU};
    endfunction

    function automatic logic op_a_signed(input alu_op_t op);
        return op inside {ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_DIV, ALU_OPCODE_REM};
    endfunction

    function automatic logic op_b_signed(input alu_op_t op);
        return op inside {ALU_OPCODE_MULH, ALU_OPCODE_DIV, ALU_OPCODE_REM};
    endfunction

endpackage

// File: rtl/rv32im_alu_seq_muldiv.sv
// Iterative multiply (shift-add) / restoring divide on magnitudes, with sign fix-up in the final step.
// Latency: XLEN steps after start; done/hi/lo are valid combinationally during the last step.
// Backpressure: none; the caller must capture hi/lo in the done cycle. flush/rst abandon the op.
module rv32im_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic            is_div,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, div_q, neg_lo_q, neg_hi_q;

    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [XLEN-1:0] step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign a_neg = a_signed & a[XLEN-1];
    assign b_neg = b_signed & b[XLEN-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // One bit step of the shared hi/lo register, mul or div depending on the captured mode.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_shift = {hi_q, lo_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        step_hi   = '0;
        step_lo   = '0;
        if (div_q) begin
            step_hi = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
        end else begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign fix-up applied to the final step: 2*XLEN negate for products, per-half for div.
    always_comb begin
        prod     = {step_hi, step_lo};
        prod_fix = neg_lo_q ? -prod : prod;
        hi       = prod_fix[2*XLEN-1:XLEN];
        lo       = prod_fix[XLEN-1:0];
        if (div_q) begin
            hi = neg_hi_q ? -step_hi : step_hi;
            lo = neg_lo_q ? -step_lo : step_lo;
        end
    end

    assign busy = busy_q;
    assign done = busy_q & (cnt_q == LAST);

    // Operand load on start, then XLEN iterations; abort on reset or flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (flush) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= a_mag;
            b_q      <= b_mag;
            div_q    <= is_div;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
        end else if (busy_q) begin
            hi_q <= step_hi;
            lo_q <= step_lo;
            if (cnt_q == LAST) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rv32im_alu_seq.sv
// Handshaked RV32IM execute ALU: base ops, M-extension mul/div, registered result held until taken.
// Latency: 1 cycle for base ops, div special cases and FAST_MUL products; XLEN+1 for iterative mul/div.
// Backpressure: result held while out_valid_o & ~out_ready_i; in_ready_o drops in BUSY or while held.
module rv32im_alu_seq
    import rv32im_alu_seq_pkg::*;
#(
    parameter int XLEN     = API_DATA_WIDTH,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [XLEN-1:0]             aluoperand_1_i,
    input  logic [XLEN-1:0]             aluoperand_2_i,
    input  logic [ALU_OPCODE_WIDTH-1:0] alu_opcode_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [XLEN-1:0]             alu_o,
    output logic                        alu_zero_o
);

    localparam int              SHW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_t state_q, state_d;

    logic [XLEN-1:0] a, b;
    alu_op_t         op;
    logic [SHW-1:0]  shamt;
    logic            is_mul, is_div, is_rem, a_sx, b_sx;
    logic            div_by_zero, div_ovf, special, single_cycle, accept;
    logic [XLEN-1:0] base_res, special_res, fast_res, imm_res;
    logic [2*XLEN-1:0] a_ext, b_ext, fast_prod;
    logic            sel_hi_q;

    logic            eng_busy, eng_done;
    logic [XLEN-1:0] eng_hi, eng_lo;

    assign a     = aluoperand_1_i;
    assign b     = aluoperand_2_i;
    assign op    = alu_opcode_i;
    assign shamt = b[SHW-1:0];

    assign is_mul = op_is_mul(op);
    assign is_div = op_is_div(op);
    assign is_rem = (op == ALU_OPCODE_REM) || (op == ALU_OPCODE_REMU);
    assign a_sx   = op_a_signed(op);
    assign b_sx   = op_b_signed(op);

    // Special divides finish immediately instead of iterating.
    assign div_by_zero = is_div && (b == '0);
    assign div_ovf     = ((op == ALU_OPCODE_DIV) || (op == ALU_OPCODE_REM)) &&
                         (a == XLEN_MIN) && (b == '1);
    assign special     = div_by_zero || div_ovf;
    assign special_res = div_by_zero ? (is_rem ? a : '1) : (is_rem ? '0 : a);

    // Single-cycle product: sign/zero-extend to 2*XLEN; the truncated product is exact.
    assign a_ext     = {{XLEN{a_sx & a[XLEN-1]}}, a};
    assign b_ext     = {{XLEN{b_sx & b[XLEN-1]}}, b};
    assign fast_prod = a_ext * b_ext;
    assign fast_res  = (op == ALU_OPCODE_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];

    assign single_cycle = !(is_mul && !FAST_MUL) && !(is_div && !special);

    assign in_ready_o = !rst_i && !flush_i &&
                        ((state_q == ALU_ST_IDLE) || ((state_q == ALU_ST_DONE) && out_ready_i));
    assign accept     = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == ALU_ST_DONE);

    // Base integer datapath; M-extension and unknown codes yield zero here.
    always_comb begin
        base_res = '0;
        case (op)
            ALU_OPCODE_ADD:  base_res = a + b;
            ALU_OPCODE_SUB:  base_res = a - b;
            ALU_OPCODE_AND:  base_res = a & b;
            ALU_OPCODE_OR:   base_res = a | b;
            ALU_OPCODE_XOR:  base_res = a ^ b;
            ALU_OPCODE_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_OPCODE_SLTU: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_OPCODE_SLL:  base_res = a << shamt;
            ALU_OPCODE_SRL:  base_res = a >> shamt;
            ALU_OPCODE_SRA:  base_res = $unsigned($signed(a) >>> shamt);
            default:         base_res = '0;
        endcase
    end

    // Result for ops that complete on the acceptance edge.
    always_comb begin
        imm_res = base_res;
        if (is_div)
            imm_res = special_res;
        else if (is_mul)
            imm_res = fast_res;
    end

    rv32im_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
        .clk      (clk_i),
        .rst      (rst_i),
        .flush    (flush_i),
        .start    (accept && !single_cycle),
        .is_div   (is_div),
        .a_signed (a_sx),
        .b_signed (b_sx),
        .a        (a),
        .b        (b),
        .busy     (eng_busy),
        .done     (eng_done),
        .hi       (eng_hi),
        .lo       (eng_lo)
    );

    // Next-state logic: flush wins; a taken result may chain straight into the next op.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ALU_ST_IDLE;
        end else begin
            case (state_q)
                ALU_ST_IDLE: begin
                    if (accept)
                        state_d = single_cycle ? ALU_ST_DONE : ALU_ST_BUSY;
                end
                ALU_ST_BUSY: begin
                    if (eng_done)
                        state_d = ALU_ST_DONE;
                    else if (!eng_busy)
                        state_d = ALU_ST_IDLE;
                end
                ALU_ST_DONE: begin
                    if (accept)
                        state_d = single_cycle ? ALU_ST_DONE : ALU_ST_BUSY;
                    else if (out_ready_i)
                        state_d = ALU_ST_IDLE;
                end
                default: state_d = ALU_ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state_q <= ALU_ST_IDLE;
        else
            state_q <= state_d;
    end

    // Result register: loads on single-cycle acceptance or on the engine's final step.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_o      <= '0;
            alu_zero_o <= 1'b1;
            sel_hi_q   <= 1'b0;
        end else if (accept && single_cycle) begin
            alu_o      <= imm_res;
            alu_zero_o <= (imm_res == '0);
        end else if (accept) begin
            sel_hi_q <= op_sel_hi(op);
        end else if ((state_q == ALU_ST_BUSY) && eng_done && !flush_i) begin
            alu_o      <= sel_hi_q ? eng_hi : eng_lo;
            alu_zero_o <= ((sel_hi_q ? eng_hi : eng_lo) == '0);
        end
    end

endmodule

// File: tb/tb_rv32im_alu_seq.sv
// Directed self-checking bench for rv32im_alu_seq (XLEN=32, iterative multiply).
// Latency: measured as edges from the acceptance edge until out_valid_o is seen.
// Backpressure: exercised by holding out_ready_i low with a pending op presented.
module tb_rv32im_alu_seq;
    import rv32im_alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    alu_op_t     opcode = ALU_OPCODE_ADD;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu;
    logic        zero;

    int errors = 0;
    int checks = 0;

    typedef struct {
        alu_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    rv32im_alu_seq #(.XLEN(32), .FAST_MUL(1'b0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .aluoperand_1_i (op1),
        .aluoperand_2_i (op2),
        .alu_opcode_i   (opcode),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .alu_o          (alu),
        .alu_zero_o     (zero)
    );

    always #5 clk = ~clk;

    // Drive one op, scramble operands after acceptance, wait (bounded) for the result, then retire it.
    task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic zf, output int lat);
        int w;
        @(negedge clk);
        opcode = op; op1 = a; op2 = b; in_valid = 1'b1; out_ready = 1'b0;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); @(negedge clk); w++;
        end
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; op1 = ~a; op2 = ~b; opcode = ALU_OPCODE_ADD;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); @(negedge clk); lat++;
        end
        res = alu; zf = zero;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (alu !== 32'h0) begin errors++; $display("FAIL reset_alu got %h exp 00000000", alu); end
        checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        opcode = ALU_OPCODE_ADD; op1 = 32'd5; op2 = 32'd7; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        checks++; if ({out_valid, alu, zero} !== {1'b1, 32'd12, 1'b0}) begin
            errors++; $display("FAIL b2b_add got v=%b r=%h z=%b exp v=1 r=0000000c z=0", out_valid, alu, zero); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
        opcode = ALU_OPCODE_SUB; op1 = 32'd3; op2 = 32'd3;
        @(posedge clk); @(negedge clk);
        checks++; if ({out_valid, alu, zero} !== {1'b1, 32'd0, 1'b1}) begin
            errors++; $display("FAIL b2b_sub got v=%b r=%h z=%b exp v=1 r=00000000 z=1", out_valid, alu, zero); end
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b exp 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_vectors(input string name, input vec_t v[]);
        logic [31:0] r; logic z; int lat;
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, r, z, lat);
            checks++; if (r !== v[i].exp) begin
                errors++; $display("FAIL %s[%0d]_value got %h exp %h", name, i, r, v[i].exp); end
            checks++; if (lat !== v[i].lat) begin
                errors++; $display("FAIL %s[%0d]_latency got %0d exp %0d", name, i, lat, v[i].lat); end
            checks++; if (z !== (v[i].exp == 32'h0)) begin
                errors++; $display("FAIL %s[%0d]_zero got %b exp %b", name, i, z, (v[i].exp == 32'h0)); end
        end
    endtask

    task automatic test_base_ops();
        vec_t v[];
        v = new[10];
        v[0] = '{ALU_OPCODE_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1};
        v[1] = '{ALU_OPCODE_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1};
        v[2] = '{ALU_OPCODE_SLL,  32'h00000001, 32'd31,       32'h80000000, 1};
        v[3] = '{ALU_OPCODE_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1};
        v[4] = '{ALU_OPCODE_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1};
        v[5] = '{ALU_OPCODE_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1};
        v[6] = '{ALU_OPCODE_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1};
        v[7] = '{ALU_OPCODE_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1};
        v[8] = '{ALU_OPCODE_SUB,  32'h00000000, 32'd1,        32'hFFFFFFFF, 1};
        v[9] = '{alu_op_t'(5'd31), 32'd5,       32'd7,        32'h00000000, 1};
        test_vectors("base", v);
    endtask

    task automatic test_mul();
        vec_t v[];
        v = new[5];
        v[0] = '{ALU_OPCODE_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33};
        v[1] = '{ALU_OPCODE_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        v[2] = '{ALU_OPCODE_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33};
        v[3] = '{ALU_OPCODE_MUL,    32'hFFFFFFFD, 32'd4,        32'hFFFFFFF4, 33};
        v[4] = '{ALU_OPCODE_MULH,   32'h40000000, 32'd4,        32'h00000001, 33};
        test_vectors("mul", v);
    endtask

    task automatic test_div();
        vec_t v[];
        v = new[10];
        v[0] = '{ALU_OPCODE_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        v[1] = '{ALU_OPCODE_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        v[2] = '{ALU_OPCODE_DIVU, 32'd100,      32'd7,        32'd14,       33};
        v[3] = '{ALU_OPCODE_REMU, 32'd100,      32'd7,        32'd2,        33};
        v[4] = '{ALU_OPCODE_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        v[5] = '{ALU_OPCODE_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        33};
        v[6] = '{ALU_OPCODE_DIVU, 32'd1234,     32'd0,        32'hFFFFFFFF, 1};
        v[7] = '{ALU_OPCODE_REMU, 32'd1234,     32'd0,        32'd1234,     1};
        v[8] = '{ALU_OPCODE_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        v[9] = '{ALU_OPCODE_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};
        test_vectors("div", v);
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        opcode = ALU_OPCODE_ADD; op1 = 32'd1; op2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        opcode = ALU_OPCODE_SUB; op1 = 32'd9; op2 = 32'd1;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({out_valid, in_ready, alu} !== {1'b1, 1'b0, 32'd3}) begin
                errors++; $display("FAIL hold[%0d] got v=%b rdy=%b r=%h exp v=1 rdy=0 r=00000003", i, out_valid, in_ready, alu); end
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL release_idle got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        logic seen; logic [31:0] r; logic z; int lat;
        @(negedge clk);
        out_ready = 1'b0;
        opcode = ALU_OPCODE_DIVU; op1 = 32'd1000; op2 = 32'd3; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); @(negedge clk); end
        flush = 1'b1;
        opcode = ALU_OPCODE_ADD; op1 = 32'd1; op2 = 32'd1; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
        @(posedge clk); @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        repeat (40) begin seen |= out_valid; @(posedge clk); @(negedge clk); end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got %b exp 0", seen); end
        run_op(ALU_OPCODE_ADD, 32'd1, 32'd1, r, z, lat);
        checks++; if (r !== 32'd2) begin errors++; $display("FAIL flush_next_value got %h exp 00000002", r); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL flush_next_latency got %0d exp 1", lat); end
        // Flush while a result is held discards it.
        @(negedge clk);
        opcode = ALU_OPCODE_ADD; op1 = 32'd2; op2 = 32'd2; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; flush = 1'b1;
        @(posedge clk); @(negedge clk);
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_done_drop got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_base_ops();
        test_mul();
        test_div();
        test_backpressure();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32im_alu_seq.md
# rv32im_alu_seq

Parametrised, handshaked successor to the single-cycle RV32IM ALU. It executes all base integer ALU operations plus the full M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) on XLEN-bit operands. Results are registered and held until the consumer accepts them. It sits in the execute stage, so the pipeline stalls on `in_ready_o`/`out_valid_o` instead of assuming a fixed latency.

## Interface
- `XLEN`, default `API_DATA_WIDTH` (32): operand/result width; must be a power of two, ≥8.
- `FAST_MUL`, default 0: 1 means multiply ops complete in one cycle using a full combinational product; 0 means iterative shift-add.
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `flush_i`  in  1  abort the in-flight op and discard any held result.
- `in_valid_i`  in  1  operands/opcode valid.
- `in_ready_o`  out  1  block can accept an op this cycle.
- `aluoperand_1_i`  in  XLEN  operand A (rs1).
- `aluoperand_2_i`  in  XLEN  operand B (rs2/imm).
- `alu_opcode_i`  in  `ALU_OPCODE_WIDTH`  operation select; base codes unchanged, M codes are new.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  consumer accepts result.
- `alu_o`  out  XLEN  result, registered.
- `alu_zero_o`  out  1  `alu_o == 0`, registered alongside `alu_o`.

## Operation
- FSM states:
  - IDLE: `in_ready_o=1`.
  - BUSY: iterating mul/div; `in_ready_o=0`.
  - DONE: `out_valid_o=1`.
- An op is accepted on `in_valid_i & in_ready_o`. Operands and opcode are captured on acceptance; later input changes are ignored.
- Base ops (ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA), and mul ops when `FAST_MUL=1`: IDLE→DONE on acceptance.
- Iterative mul ops and all div/rem ops: IDLE→BUSY. There is one bit step per cycle, with the step counter running 0..XLEN-1. BUSY→DONE after the last step; sign fix-up is folded into the final step.
- Division special cases bypass iteration and go IDLE→DONE:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give operand A.
  - Signed overflow (A=−2^(XLEN−1), B=−1): DIV gives A; REM gives 0.
- DONE→IDLE on `out_ready_i`.
  - In DONE, `in_ready_o = out_ready_i`, so back-to-back single-cycle ops sustain 1 op/cycle.
  - If an op is accepted in the same cycle as the result is taken, the FSM goes to that op's next state directly.
- Unknown opcode: result 0, latency 1.
- Width rules:
  - Shift amount is `aluoperand_2_i[$clog2(XLEN)-1:0]`. SRA is arithmetic (signed shift).
  - SLT is signed and SLTU unsigned; the result is zero-extended 0/1.
  - MUL returns the low XLEN bits. MULH/MULHSU/MULHU return the high XLEN bits of the 2·XLEN product (signed×signed, signed×unsigned, unsigned×unsigned respectively).
  - DIV rounds toward zero; REM takes the sign of the dividend.
- `flush_i` takes priority over everything except `rst_i`:
  - Next state is IDLE and `out_valid_o` goes 0; the held result is discarded.
  - An op presented in the flush cycle is not accepted; `in_ready_o=0` that cycle.
- `rst_i` sets state IDLE, `out_valid_o=0`, `alu_o=0`, `alu_zero_o=1` and the step counter to 0. `in_ready_o=0` while `rst_i` is high. Reset mid-BUSY abandons the op.

## Timing
- Acceptance at edge N:
  - Base, special-case div, and `FAST_MUL` mul: `out_valid_o=1` after edge N+1.
  - Iterative mul/div: `out_valid_o=1` after edge N+XLEN+1 (33 cycles at XLEN=32).
- `alu_o`/`alu_zero_o` stay stable while `out_valid_o & ~out_ready_i`.
- `in_ready_o` is combinational from state, `out_ready_i`, `flush_i` and `rst_i`. There is no combinational path from operands to any output.

## Structure
- Add to `DEFINITIONS.v`: the M-extension opcode macros `ALU_OPCODE_MUL` … `ALU_OPCODE_REMU`, widening `ALU_OPCODE_WIDTH` if needed, plus FSM state encodings `ALU_ST_IDLE/BUSY/DONE`.
- Sub-module `rv32im_muldiv_iter`: XLEN-parameterised iterative engine.
  - Shared accumulator/shift register; shift-add for mul, restoring division for div.
  - Ports `start`, sign controls, `busy`, `done`, `hi`/`lo` outputs.
- The top level holds the FSM, the base-op datapath, the special-case detection and the result register.

## Test plan
- Reset: hold `rst_i` 2 cycles → `out_valid_o=0`, `alu_o=0`, `alu_zero_o=1`, `in_ready_o=0` during reset and 1 after.
- Back-to-back base ops:
  - ADD 5+7, then SUB 3−3, with `out_ready_i=1` → 12 then 0 on consecutive cycles; `alu_zero_o=1` on the second result.
  - SRA 0x80000000 by 4 → 0xF8000000.
- Multiply, XLEN=32, FAST_MUL=0:
  - MULH 0xFFFFFFFF×0xFFFFFFFF → 0 after 33 cycles; MULHU on the same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- Division:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU x/0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000/−1 → 0x80000000, REM → 0, both in 1 cycle.
- Back-pressure: hold `out_ready_i=0` 5 cycles after DONE → result stable, `in_ready_o=0`; release → accepted, IDLE next.
- Flush: assert `flush_i` at BUSY step 10 of DIVU → `out_valid_o` never rises; the next ADD 1+1 returns 2 after 1 cycle.
